// File: rtl/nios_pio_ext.sv
// Avalon-MM parallel I/O peripheral: per-bit direction, atomic set/clear of the
// output register, synchronised inputs with edge capture and a masked interrupt.
module nios_pio_ext #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    EDGE_TYPE   = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] out_en,
    output logic                  irq
);

    localparam int              PRIME_MAX  = SYNC_STAGES + 1;
    localparam int              PW         = $clog2(PRIME_MAX + 1);
    localparam logic [PW-1:0]   PRIME_DONE = PW'(PRIME_MAX);

    logic [DATA_WIDTH-1:0] r_data_out;
    logic [DATA_WIDTH-1:0] r_dir;
    logic [DATA_WIDTH-1:0] r_irqmask;
    logic [DATA_WIDTH-1:0] r_edgecap;
    logic [31:0]           r_readdata;
    logic                  r_irq;
    logic [DATA_WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] r_prev;
    logic [PW-1:0]         r_prime;

    logic                  w_wr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_s;
    logic [DATA_WIDTH-1:0] w_data_out_next;
    logic [DATA_WIDTH-1:0] w_dir_next;
    logic [DATA_WIDTH-1:0] w_irqmask_next;
    logic [DATA_WIDTH-1:0] w_clear;
    logic [DATA_WIDTH-1:0] w_edge_raw;
    logic [DATA_WIDTH-1:0] w_edge;
    logic [DATA_WIDTH-1:0] w_edgecap_next;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [31:0]           w_rd_full;
    logic                  w_unused_wdata;

    assign w_wr           = chipselect & ~write_n;
    assign w_wdata        = writedata[DATA_WIDTH-1:0];
    assign w_s            = r_sync[SYNC_STAGES-1];
    assign w_unused_wdata = &{1'b0, writedata};

    // Register write decode, including the atomic set/clear views of data_out
    always_comb begin
        w_data_out_next = r_data_out;
        w_dir_next      = r_dir;
        w_irqmask_next  = r_irqmask;
        w_clear         = '0;
        if (w_wr) begin
            case (address)
                3'd0:    w_data_out_next = w_wdata;
                3'd1:    w_dir_next      = w_wdata;
                3'd2:    w_irqmask_next  = w_wdata;
                3'd3:    w_clear         = w_wdata;
                3'd4:    w_data_out_next = r_data_out | w_wdata;
                3'd5:    w_data_out_next = r_data_out & ~w_wdata;
                default: w_clear         = '0;
            endcase
        end else begin
            w_clear = '0;
        end
    end

    // Edge selection, gated off until the synchroniser has been primed
    always_comb begin
        case (EDGE_TYPE)
            32'sd0:  w_edge_raw = w_s & ~r_prev;
            32'sd1:  w_edge_raw = ~w_s & r_prev;
            default: w_edge_raw = w_s ^ r_prev;
        endcase
        if (r_prime == PRIME_DONE) begin
            w_edge = w_edge_raw;
        end else begin
            w_edge = '0;
        end
        // A fresh edge beats a simultaneous W1C on the same bit
        w_edgecap_next = (r_edgecap & ~w_clear) | w_edge;
    end

    // Read multiplexer; bits above DATA_WIDTH stay zero
    always_comb begin
        case (address)
            3'd0:    w_rd_data = (r_data_out & r_dir) | (w_s & ~r_dir);
            3'd1:    w_rd_data = r_dir;
            3'd2:    w_rd_data = r_irqmask;
            3'd3:    w_rd_data = r_edgecap;
            default: w_rd_data = '0;
        endcase
        w_rd_full                 = '0;
        w_rd_full[DATA_WIDTH-1:0] = w_rd_data;
    end

    // Input synchroniser, previous-value register and prime counter
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev  <= '0;
            r_prime <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_s;
            if (r_prime != PRIME_DONE) begin
                r_prime <= r_prime + PW'(1);
            end else begin
                r_prime <= r_prime;
            end
        end
    end

    // Control/status registers, registered read data and interrupt request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out <= RESET_VALUE;
            r_dir      <= '0;
            r_irqmask  <= '0;
            r_edgecap  <= '0;
            r_readdata <= 32'h0000_0000;
            r_irq      <= 1'b0;
        end else begin
            r_data_out <= w_data_out_next;
            r_dir      <= w_dir_next;
            r_irqmask  <= w_irqmask_next;
            r_edgecap  <= w_edgecap_next;
            r_readdata <= w_rd_full;
            r_irq      <= |(r_edgecap & r_irqmask);
        end
    end

    assign out_port = r_data_out;
    assign out_en   = r_dir;
    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_nios_pio_ext.sv
// Directed bench for nios_pio_ext: a rising-edge and an any-edge instance share
// the bus and pins; each task checks its own scenario against hand-worked values.
module tb_nios_pio_ext;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd0, rd2;
    logic [7:0]  out0, out2, oen0, oen2;
    logic        irq0, irq2;

    int n_cmp;
    int n_err;

    nios_pio_ext #(.DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .RESET_VALUE(8'hA5)) u_dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in_port),
        .out_port(out0), .out_en(oen0), .irq(irq0)
    );

    nios_pio_ext #(.DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .RESET_VALUE(8'hA5)) u_dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(in_port),
        .out_port(out2), .out_en(oen2), .irq(irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        in_port = 8'hFF;
        tick(3);
        n_cmp++; if (out0 !== 8'hA5) begin n_err++; $display("FAIL rst_out0: got %h want a5", out0); end
        n_cmp++; if (out2 !== 8'hA5) begin n_err++; $display("FAIL rst_out2: got %h want a5", out2); end
        n_cmp++; if (oen0 !== 8'h00) begin n_err++; $display("FAIL rst_oen: got %h want 00", oen0); end
        n_cmp++; if (irq0 !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b want 0", irq0); end
        n_cmp++; if (rd0 !== 32'h0) begin n_err++; $display("FAIL rst_rd: got %h want 0", rd0); end
        reset   = 1'b0;
        address = 3'd3;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            n_cmp++;
            if ({rd0, rd2} !== 64'h0 || irq0 !== 1'b0 || irq2 !== 1'b0) begin
                n_err++;
                $display("FAIL rst_no_capture cycle %0d: got rd0=%h rd2=%h irq=%b%b want 0", i, rd0, rd2, irq0, irq2);
            end
        end
    endtask

    task automatic test_data_dir;
        bus_write(3'd1, 32'h0F);
        bus_write(3'd0, 32'h3C);
        in_port = 8'hF0;
        tick(3);
        n_cmp++; if (oen0 !== 8'h0F) begin n_err++; $display("FAIL dir_oen: got %h want 0f", oen0); end
        n_cmp++; if (out0 !== 8'h3C) begin n_err++; $display("FAIL dir_out: got %h want 3c", out0); end
        address = 3'd1;
        tick(1);
        n_cmp++; if (rd0 !== 32'h0000_000F) begin n_err++; $display("FAIL dir_read: got %h want 0000000f", rd0); end
        address = 3'd0;
        tick(1);
        n_cmp++; if (rd0 !== 32'h0000_00FC) begin n_err++; $display("FAIL data_mix0: got %h want 000000fc", rd0); end
        n_cmp++; if (rd2 !== 32'h0000_00FC) begin n_err++; $display("FAIL data_mix2: got %h want 000000fc", rd2); end
    endtask

    task automatic test_set_clr;
        bus_write(3'd0, 32'h00);
        n_cmp++; if (out0 !== 8'h00) begin n_err++; $display("FAIL data_zero: got %h want 00", out0); end
        bus_write(3'd4, 32'h81);
        n_cmp++; if (out0 !== 8'h81) begin n_err++; $display("FAIL outset: got %h want 81", out0); end
        bus_write(3'd5, 32'h01);
        n_cmp++; if (out0 !== 8'h80) begin n_err++; $display("FAIL outclr: got %h want 80", out0); end
        bus_write(3'd4, 32'h00);
        n_cmp++; if (out0 !== 8'h80) begin n_err++; $display("FAIL outset_zero: got %h want 80", out0); end
        bus_write(3'd5, 32'h00);
        n_cmp++; if (out0 !== 8'h80) begin n_err++; $display("FAIL outclr_zero: got %h want 80", out0); end
        address = 3'd4;
        tick(1);
        n_cmp++; if (rd0 !== 32'h0) begin n_err++; $display("FAIL outset_read: got %h want 0", rd0); end
        bus_write(3'd6, 32'hFF);
        address = 3'd1;
        tick(1);
        n_cmp++; if (rd0 !== 32'h0F || out0 !== 8'h80) begin n_err++; $display("FAIL off6_ignored: got dir=%h out=%h want 0f/80", rd0, out0); end
    endtask

    task automatic test_irq;
        in_port = 8'h00;
        tick(4);
        bus_write(3'd3, 32'hFF);
        bus_write(3'd2, 32'h04);
        address = 3'd3;
        tick(1);
        n_cmp++; if (rd0 !== 32'h0 || irq0 !== 1'b0) begin n_err++; $display("FAIL irq_idle: got rd=%h irq=%b want 0/0", rd0, irq0); end
        in_port = 8'h04;
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            n_cmp++;
            if (irq0 !== (k == 4) || rd0 !== ((k == 4) ? 32'h4 : 32'h0)) begin
                n_err++;
                $display("FAIL irq_latency edge %0d: got rd=%h irq=%b want rd=%h irq=%b", k, rd0, irq0, (k == 4) ? 32'h4 : 32'h0, (k == 4));
            end
        end
        bus_write(3'd3, 32'h04);
        n_cmp++; if (irq0 !== 1'b1) begin n_err++; $display("FAIL irq_clear_lag: got %b want 1", irq0); end
        tick(1);
        n_cmp++; if (irq0 !== 1'b0) begin n_err++; $display("FAIL irq_cleared: got %b want 0", irq0); end
        n_cmp++; if (rd0 !== 32'h0) begin n_err++; $display("FAIL edgecap_w1c: got %h want 0", rd0); end
    endtask

    task automatic test_any_edge;
        bus_write(3'd3, 32'hFF);
        address = 3'd3;
        in_port = 8'h05;
        tick(4);
        n_cmp++; if (rd2 !== 32'h01) begin n_err++; $display("FAIL any_rise: got %h want 01", rd2); end
        n_cmp++; if (rd0 !== 32'h01) begin n_err++; $display("FAIL rise_rise: got %h want 01", rd0); end
        bus_write(3'd3, 32'h01);
        tick(1);
        n_cmp++; if (rd2 !== 32'h0) begin n_err++; $display("FAIL any_clear: got %h want 0", rd2); end
        in_port = 8'h04;
        tick(4);
        n_cmp++; if (rd2 !== 32'h01) begin n_err++; $display("FAIL any_fall: got %h want 01", rd2); end
        n_cmp++; if (rd0 !== 32'h00) begin n_err++; $display("FAIL rise_ignores_fall: got %h want 00", rd0); end
        bus_write(3'd3, 32'hFF);
        tick(1);
        n_cmp++; if (rd2 !== 32'h0) begin n_err++; $display("FAIL any_clear2: got %h want 0", rd2); end
        in_port = 8'h05;
        tick(2);
        bus_write(3'd3, 32'h01);
        tick(1);
        n_cmp++; if (rd2 !== 32'h01) begin n_err++; $display("FAIL edge_beats_clear: got %h want 01", rd2); end
        tick(1);
        n_cmp++; if (rd2 !== 32'h01) begin n_err++; $display("FAIL edge_beats_clear_hold: got %h want 01", rd2); end
    endtask

    task automatic test_mid_reset;
        bus_write(3'd3, 32'hFF);
        bus_write(3'd2, 32'hFF);
        address = 3'd3;
        in_port = 8'hFA;
        tick(4);
        n_cmp++; if (rd2 !== 32'hFF || irq2 !== 1'b1) begin n_err++; $display("FAIL pre_reset: got rd=%h irq=%b want ff/1", rd2, irq2); end
        reset = 1'b1;
        tick(1);
        n_cmp++; if (irq2 !== 1'b0 || rd2 !== 32'h0) begin n_err++; $display("FAIL mid_reset: got rd=%h irq=%b want 0/0", rd2, irq2); end
        n_cmp++; if (out2 !== 8'hA5 || oen2 !== 8'h00) begin n_err++; $display("FAIL mid_reset_out: got out=%h oen=%h want a5/00", out2, oen2); end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            n_cmp++;
            if (rd2 !== 32'h0 || irq2 !== 1'b0) begin
                n_err++;
                $display("FAIL post_reset_prime cycle %0d: got rd=%h irq=%b want 0/0", i, rd2, irq2);
            end
        end
        address = 3'd2;
        tick(1);
        n_cmp++; if (rd2 !== 32'h0) begin n_err++; $display("FAIL post_reset_mask: got %h want 0", rd2); end
        address = 3'd3;
        in_port = 8'h7A;
        tick(4);
        n_cmp++; if (rd2 !== 32'h80) begin n_err++; $display("FAIL post_reset_capture: got %h want 80", rd2); end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'hFF;
        test_reset;
        test_data_dir;
        test_set_clr;
        test_irq;
        test_any_edge;
        test_mid_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
